// File: rtl/sequenciador_entradas_if.sv
// Keypad strobe plus classifier handshake/field-bank bus for sequenciador_entradas.
// master: the entry controller; slave: keypad/classifier side.
interface sequenciador_entradas_if #(
  parameter int unsigned NUM_CAMPOS = 7,
  parameter int unsigned LARGURA    = 14
);
  logic                            tecla_valida;
  logic [3:0]                      tecla_codigo;
  logic                            calc_start;
  logic                            calc_done;
  logic                            calc_resultado;
  logic [NUM_CAMPOS*LARGURA-1:0]   campos;

  modport master (
    input  tecla_valida, tecla_codigo, calc_done, calc_resultado,
    output calc_start, campos
  );

  modport slave (
    output tecla_valida, tecla_codigo, calc_done, calc_resultado,
    input  calc_start, campos
  );
endinterface

// File: rtl/sequenciador_entradas.sv
// sequenciador_entradas: keypad-driven entry of the seven clinical fields,
// classifier start/done handshake and outcome hold.
// Optional macro SEQ_TIMEOUT_EN: classifier timeout counter and ERRO state.
module sequenciador_entradas #(
  parameter int unsigned NUM_CAMPOS     = 7,
  parameter int unsigned LARGURA        = 14,
  parameter int unsigned MAX_DIGITOS    = 4,
  parameter int unsigned TIMEOUT_CICLOS = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sequenciador_entradas_if.master   bus,
  output logic [2:0]                campo_atual,
  output logic [15:0]               display_bcd,
  output logic                      resultado,
  output logic                      resultado_valido,
  output logic                      erro
);

  localparam int unsigned W_CAMPOS = NUM_CAMPOS * LARGURA;
  localparam logic [3:0]  COD_ENTER  = 4'd10;
  localparam logic [3:0]  COD_LIMPAR = 4'd11;
  localparam logic [2:0]  MAX_DIG    = 3'(MAX_DIGITOS);
  localparam logic [2:0]  ULTIMO     = 3'(NUM_CAMPOS - 1);

`ifdef SEQ_TIMEOUT_EN
  typedef enum logic [1:0] {ENTRADA, CALCULO, RESULTADO, ERRO} estado_t;
  localparam int unsigned TW        = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TW-1:0] TIMER_FIM = TW'(TIMEOUT_CICLOS - 1);
  logic [TW-1:0] timer, timer_n;
`else
  typedef enum logic [1:0] {ENTRADA, CALCULO, RESULTADO} estado_t;
`endif

  estado_t               estado, estado_n;
  logic [LARGURA-1:0]    acc, acc_n;
  logic [2:0]            cnt, cnt_n;
  logic [W_CAMPOS-1:0]   campos_q, campos_n;
  logic [2:0]            campo_n;
  logic [15:0]           disp_n;
  logic                  start_q, start_n;
  logic                  res_n;
  logic                  eh_digito, eh_enter, eh_limpar;

  assign eh_digito = bus.tecla_valida && (bus.tecla_codigo <= 4'd9);
  assign eh_enter  = bus.tecla_valida && (bus.tecla_codigo == COD_ENTER);
  assign eh_limpar = bus.tecla_valida && (bus.tecla_codigo == COD_LIMPAR);

  assign bus.campos       = campos_q;
  assign bus.calc_start   = start_q;
  assign resultado_valido = (estado == RESULTADO);
`ifdef SEQ_TIMEOUT_EN
  assign erro = (estado == ERRO);
`else
  assign erro = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= ENTRADA;
    else        estado <= estado_n;
  end

  // Next-state and next datapath values; limpar overrides every state
  always_comb begin
    estado_n = estado;
    acc_n    = acc;
    cnt_n    = cnt;
    campos_n = campos_q;
    campo_n  = campo_atual;
    disp_n   = display_bcd;
    start_n  = 1'b0;
    res_n    = resultado;
`ifdef SEQ_TIMEOUT_EN
    timer_n  = '0;
`endif
    if (eh_limpar) begin
      estado_n = ENTRADA;
      acc_n    = '0;
      cnt_n    = '0;
      campos_n = '0;
      campo_n  = '0;
      disp_n   = '0;
      res_n    = 1'b0;
    end else begin
      case (estado)
        ENTRADA: begin
          if (eh_digito) begin
            if (cnt < MAX_DIG) begin
              acc_n  = acc * LARGURA'(10) + LARGURA'(bus.tecla_codigo);
              disp_n = {display_bcd[11:0], bus.tecla_codigo};
              cnt_n  = cnt + 3'd1;
            end
          end else if (eh_enter) begin
            campos_n[campo_atual*LARGURA +: LARGURA] = acc;
            acc_n   = '0;
            cnt_n   = '0;
            disp_n  = '0;
            campo_n = campo_atual + 3'd1;
            if (campo_atual == ULTIMO) begin
              estado_n = CALCULO;
              start_n  = 1'b1;
            end
          end
        end
        CALCULO: begin
          // calc_done is not looked at during the start pulse cycle
          if (!start_q && bus.calc_done) begin
            res_n    = bus.calc_resultado;
            disp_n   = {15'd0, bus.calc_resultado};
            estado_n = RESULTADO;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (timer == TIMER_FIM) begin
            disp_n   = 16'hEEEE;
            estado_n = ERRO;
          end else begin
            timer_n = timer + 1'b1;
          end
`endif
        end
        RESULTADO: begin
          if (eh_enter) begin
            campos_n = '0;
            campo_n  = '0;
            disp_n   = '0;
            estado_n = ENTRADA;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        ERRO: begin
          if (eh_enter) begin
            acc_n    = '0;
            cnt_n    = '0;
            campos_n = '0;
            campo_n  = '0;
            disp_n   = '0;
            res_n    = 1'b0;
            estado_n = ENTRADA;
          end
        end
`endif
        default: estado_n = ENTRADA;
      endcase
    end
  end

  // Datapath registers: accumulator, digit count, field bank, displays, handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      campos_q    <= '0;
      campo_atual <= '0;
      display_bcd <= '0;
      start_q     <= 1'b0;
      resultado   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timer       <= '0;
`endif
    end else begin
      acc         <= acc_n;
      cnt         <= cnt_n;
      campos_q    <= campos_n;
      campo_atual <= campo_n;
      display_bcd <= disp_n;
      start_q     <= start_n;
      resultado   <= res_n;
`ifdef SEQ_TIMEOUT_EN
      timer       <= timer_n;
`endif
    end
  end

endmodule
